hdmi_island_sched: RTL and testbench
====================================

HDMI_ISLAND_SCHED -- requirements
Module: hdmi_island_sched

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 1650: total pixels per line (hcnt runs 0..H_TOTAL-1).
REQ-003 SHALL have parameter CTL_MIN, default 12: minimum control-period cycles before any preamble.
REQ-004 SHALL have parameter MAX_PKTS, default 18: maximum packets per data island.
REQ-005 SHALL have port pix_clk, input, 1: pixel clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port hcnt, input, 12: horizontal pixel counter from the timing generator.
REQ-008 SHALL have port vid_line, input, 1: current line carries active video.
REQ-009 SHALL have port vid_next, input, 1: next line carries active video.
REQ-010 SHALL have port enable, input, 1: HDMI mode; when low, no islands are started.
REQ-011 SHALL have port req, input, 2: packet requests from source 0 (InfoFrame/ACR) and source 1 (audio).
REQ-012 SHALL have port gnt, output, 2: one-hot grant, held for all 32 data cycles of a packet.
REQ-013 SHALL have port pkt_start, output, 1: pulse on the first data cycle of a packet.
REQ-014 SHALL have port pkt_done, output, 1: pulse on the 32nd data cycle of a packet.
REQ-015 SHALL have port pkt_idx, output, 5: data-cycle index 0..31 within the current packet.
REQ-016 SHALL have port ctl, output, 4: preamble code {ctl0,ctl1,ctl2,ctl3} to the green/red encoders.
REQ-017 SHALL have port ade, output, 1: data-island data period (TERC4) enable.
REQ-018 SHALL have port gb, output, 1: data-island guard band enable.
REQ-019 SHALL have port err, output, 1: one-cycle pulse on a timing violation.

Function
REQ-020 SHALL register all outputs; each output corresponds to the hcnt value of the previous cycle.
REQ-021 SHALL treat a cycle as blanking when hcnt >= H_ACTIVE or vid_line = 0.
REQ-022 SHALL define the limit L as H_TOTAL-10 when vid_next = 1, else H_TOTAL.
REQ-023 SHALL maintain ctl_cnt: cleared during active video and during island states; incremented (saturating at 63) in IDLE blanking cycles.
REQ-024 SHALL implement FSM states IDLE, PRE (8 cycles), LGB (2), DATA (32 per packet), TGB (2).
REQ-025 SHALL go IDLE->PRE only when all hold: blanking, enable = 1, |req = 1, ctl_cnt >= CTL_MIN, and hcnt+44+CTL_MIN <= L.
REQ-026 SHALL go PRE->LGB after 8 cycles, LGB->DATA after 2 cycles, and TGB->IDLE after 2 cycles.
REQ-027 SHALL, on the last DATA cycle, stay in DATA for a new packet only when |req = 1, enable = 1, packets sent < MAX_PKTS, and hcnt+35+CTL_MIN <= L; otherwise go to TGB.
REQ-028 SHALL arbitrate at each packet start (entry to DATA from LGB, or a DATA->DATA continuation) round-robin: a single requester wins; on contention the source not served last wins.
REQ-029 SHALL keep gnt constant for the whole packet; changes on req during a packet SHALL be ignored.
REQ-030 SHALL output ctl = 1010 in PRE; 1000 when hcnt is in [H_TOTAL-10, H_TOTAL-3] and vid_next = 1 and the FSM is IDLE; otherwise 0000.
REQ-031 SHALL output gb = 1 only in LGB/TGB, and ade = 1 only in DATA.
REQ-032 SHALL, when enable falls mid-island, finish the current packet and TGB without starting new packets.
REQ-033 SHALL, when the FSM is not IDLE while vid_line = 1 and hcnt < H_ACTIVE, force IDLE, drop all outputs to 0 next cycle, and pulse err.

Reset
REQ-034 SHALL, on rst_in, asynchronously force IDLE, gnt = 00, pkt_start = pkt_done = ade = gb = err = 0, ctl = 0000, pkt_idx = 0, ctl_cnt = 0, and the round-robin pointer so source 0 wins the first contention.

Verification
REQ-035 SHALL verify: defaults, vid_line = vid_next = 1, req = 01 from hcnt = 1280 -> PRE starts when ctl_cnt reaches 12; 8x ctl = 1010, 2x gb, 32x ade with gnt = 01, 2x gb.
REQ-036 SHALL verify: req = 11 held -> consecutive packets alternate gnt 01,10,01...; they stop when hcnt+47 > 1640, and the island ends before hcnt 1640.
REQ-037 SHALL verify: req = 01 first asserted at hcnt = 1585 -> no island (1585+56 > 1640); ctl = 1000 for hcnt 1640..1647.
REQ-038 SHALL verify: vid_line = vid_next = 0 with req = 10 held -> each island carries at most 18 packets; islands repeat after >= 12 control cycles.
REQ-039 SHALL verify: rst_in asserted mid-DATA (pkt_idx = 15) -> all outputs 0 immediately; after release, source 0 wins the first contention.
REQ-040 SHALL verify: enable dropped during PRE -> 1 packet, TGB, then IDLE; hcnt forced into active video mid-island -> err pulse and outputs 0.

Source files
------------

// File: rtl/hdmi_island_sched.sv
// HDMI data-island scheduler: control period, preamble, guard bands
// and round-robin packet slots, timed off the horizontal counter.
module hdmi_island_sched #(
  parameter int H_ACTIVE = 1280,
  parameter int H_TOTAL  = 1650,
  parameter int CTL_MIN  = 12,
  parameter int MAX_PKTS = 18
) (
  input  logic        pix_clk,
  input  logic        rst_in,
  input  logic [11:0] hcnt,
  input  logic        vid_line,
  input  logic        vid_next,
  input  logic        enable,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        pkt_start,
  output logic        pkt_done,
  output logic [4:0]  pkt_idx,
  output logic [3:0]  ctl,
  output logic        ade,
  output logic        gb,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LGB,
    S_DATA,
    S_TGB
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  npk_q, npk_d;
  logic [5:0]  cc_q, cc_d;
  logic        last_q, last_d;
  logic        start_pkt;

  logic [1:0]  gnt_d;
  logic        start_d, done_d;
  logic [4:0]  idx_d;
  logic [3:0]  ctl_d;
  logic        ade_d, gb_d;

  logic [13:0] h_ext, lim;
  logic        blank, violate;
  logic        fit_isl, fit_pkt;
  logic        go_isl, more, pre_win;

  assign h_ext = {2'b00, hcnt};
  assign lim = vid_next ? 14'(H_TOTAL - 10)
                        : 14'(H_TOTAL);
  assign blank = (hcnt >= 12'(H_ACTIVE)) || !vid_line;
  assign violate = (state_q != S_IDLE) && vid_line
                && (hcnt < 12'(H_ACTIVE));
  // Room for the rest of the island plus a full control period.
  assign fit_isl = (h_ext + 14'(44 + CTL_MIN)) <= lim;
  assign fit_pkt = (h_ext + 14'(35 + CTL_MIN)) <= lim;
  assign go_isl = blank && enable && (|req)
               && (32'(cc_q) >= CTL_MIN) && fit_isl;
  assign more = (|req) && enable
             && (32'(npk_q) < MAX_PKTS) && fit_pkt;
  assign pre_win = vid_next
                && (hcnt >= 12'(H_TOTAL - 10))
                && (hcnt <= 12'(H_TOTAL - 3));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 5'd1;
    start_pkt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (go_isl) state_d = S_PRE;
      end
      S_PRE: begin
        if (cnt_q == 5'd7) begin
          state_d = S_LGB;
          cnt_d   = '0;
        end
      end
      S_LGB: begin
        if (cnt_q == 5'd1) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          start_pkt = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == 5'd31) begin
          if (more) start_pkt = 1'b1;
          else      state_d   = S_TGB;
        end
      end
      S_TGB: begin
        if (cnt_q == 5'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (violate) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      start_pkt = 1'b0;
    end
  end

  always_comb begin
    npk_d  = npk_q;
    last_d = last_q;
    gnt_d  = gnt;
    if (state_d != S_DATA) gnt_d = '0;
    if (state_d == S_IDLE) npk_d = '0;
    if (start_pkt) begin
      npk_d = npk_q + 5'd1;
      unique case (1'b1)
        (req == 2'b01): begin
          gnt_d  = 2'b01;
          last_d = 1'b0;
        end
        (req == 2'b10): begin
          gnt_d  = 2'b10;
          last_d = 1'b1;
        end
        (req == 2'b11): begin
          gnt_d  = last_q ? 2'b01 : 2'b10;
          last_d = ~last_q;
        end
        default: gnt_d = '0;
      endcase
    end
  end

  always_comb begin
    ade_d   = (state_d == S_DATA);
    gb_d    = (state_d == S_LGB) || (state_d == S_TGB);
    idx_d   = ade_d ? cnt_d : 5'd0;
    start_d = ade_d && (cnt_d == 5'd0);
    done_d  = ade_d && (cnt_d == 5'd31);
    ctl_d   = 4'b0000;
    if (state_d == S_PRE)
      ctl_d = 4'b1010;
    else if (state_d == S_IDLE && pre_win)
      ctl_d = 4'b1000;
    cc_d = '0;
    if (blank && state_d == S_IDLE)
      cc_d = (cc_q == 6'd63) ? cc_q : cc_q + 6'd1;
  end

  always_ff @(posedge pix_clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      npk_q     <= '0;
      cc_q      <= '0;
      last_q    <= 1'b1;
      gnt       <= '0;
      pkt_start <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_idx   <= '0;
      ctl       <= '0;
      ade       <= 1'b0;
      gb        <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      npk_q     <= npk_d;
      cc_q      <= cc_d;
      last_q    <= last_d;
      gnt       <= gnt_d;
      pkt_start <= start_d;
      pkt_done  <= done_d;
      pkt_idx   <= idx_d;
      ctl       <= ctl_d;
      ade       <= ade_d;
      gb        <= gb_d;
      err       <= violate;
    end
  end

endmodule

// File: tb/tb_hdmi_island_sched.sv
// Bench for hdmi_island_sched: line-level vector table, directed
// corner sequences and a randomized run against an offset-based model.
module tb_hdmi_island_sched;

  localparam int HA   = 1280;
  localparam int HT   = 1650;
  localparam int CM   = 12;
  localparam int MAXP = 18;

  logic        pix_clk = 1'b0;
  logic        rst_in  = 1'b1;
  logic [11:0] hcnt    = '0;
  logic        vid_line = 1'b0;
  logic        vid_next = 1'b0;
  logic        enable   = 1'b0;
  logic [1:0]  req      = '0;
  logic [1:0]  gnt;
  logic        pkt_start, pkt_done;
  logic [4:0]  pkt_idx;
  logic [3:0]  ctl;
  logic        ade, gb, err;

  int errors = 0;
  int checks = 0;

  hdmi_island_sched dut (
    .pix_clk(pix_clk), .rst_in(rst_in), .hcnt(hcnt),
    .vid_line(vid_line), .vid_next(vid_next),
    .enable(enable), .req(req), .gnt(gnt),
    .pkt_start(pkt_start), .pkt_done(pkt_done),
    .pkt_idx(pkt_idx), .ctl(ctl), .ade(ade),
    .gb(gb), .err(err)
  );

  always #5 pix_clk = ~pix_clk;

  function automatic logic [15:0] outs();
    return {gnt, pkt_start, pkt_done, pkt_idx,
            ctl, ade, gb, err};
  endfunction

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int h);
    hcnt = 12'(h);
    @(posedge pix_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    hcnt = '0;
    vid_line = 1'b0;
    vid_next = 1'b0;
    enable = 1'b1;
    req = '0;
    @(posedge pix_clk);
    #1;
    check("reset_outs", 32'(outs()), 0);
    @(posedge pix_clk);
    #1;
    rst_in = 1'b0;
  endtask

  // Reference model: tracks the island as an offset from its first
  // preamble cycle and decides each packet slot when it comes up.
  bit          m_isl;
  int          m_off, m_npk, m_tgb, m_cc;
  bit          m_last;
  logic [1:0]  m_gnt;
  logic [15:0] e_out;

  task automatic model_reset();
    m_isl = 0; m_off = 0; m_npk = 0; m_tgb = -1;
    m_cc = 0; m_last = 1; m_gnt = '0;
  endtask

  task automatic arbitrate(input logic [1:0] rq);
    case (rq)
      2'b01: begin m_gnt = 2'b01; m_last = 0; end
      2'b10: begin m_gnt = 2'b10; m_last = 1; end
      2'b11: begin
        m_gnt = m_last ? 2'b01 : 2'b10;
        m_last = !m_last;
      end
      default: m_gnt = 2'b00;
    endcase
  endtask

  task automatic model_step(input int h, input bit vl,
                            input bit vn, input bit en,
                            input logic [1:0] rq);
    bit blank;
    int lim, idx;
    blank = (h >= HA) || !vl;
    lim = vn ? HT - 10 : HT;
    e_out = '0;
    if (m_isl && vl && h < HA) begin
      e_out = 16'h0001;
      m_isl = 0;
      m_cc = 0;
      return;
    end
    if (m_isl) begin
      m_off++;
      if (m_tgb < 0 && m_off >= 10 && (m_off - 10) % 32 == 0) begin
        if (m_npk == 0 || (rq != 0 && en && m_npk < MAXP
                           && h + 35 + CM <= lim)) begin
          m_npk++;
          arbitrate(rq);
        end else begin
          m_tgb = m_off;
        end
      end
      if (!(m_tgb >= 0 && m_off >= m_tgb + 2)) begin
        m_cc = 0;
        if (m_off < 8) e_out = 16'h0050;
        else if (m_off < 10 || m_tgb >= 0) e_out = 16'h0002;
        else begin
          idx = (m_off - 10) % 32;
          e_out = {m_gnt, idx == 0, idx == 31, 5'(idx),
                   4'b0000, 3'b100};
        end
        return;
      end
      m_isl = 0;
    end
    if (blank && en && rq != 0 && m_cc >= CM
        && h + 44 + CM <= lim) begin
      m_isl = 1; m_off = 0; m_npk = 0; m_tgb = -1; m_cc = 0;
      e_out = 16'h0050;
      return;
    end
    m_cc = blank ? ((m_cc < 63) ? m_cc + 1 : 63) : 0;
    if (vn && h >= HT - 10 && h <= HT - 3) e_out = 16'h0040;
  endtask

  typedef struct packed {
    bit         vl, vn, en;
    logic [1:0] rq;
    int         req_on, pre, npk;
    logic [1:0] g0;
    int         endh, pre2, c1000;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 2'b01, 1280, 1292, 10, 2'b01, 1623, -1, 8};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 2'b11, 1280, 1292, 10, 2'b01, 1623, -1, 8};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 2'b01, 1585, -1, 0, 2'b00, -1, -1, 8};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 0, 12, 18, 2'b10, 599, 612, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'b01, 1280, 1292, 10, 2'b01, 1623, -1, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 2'b11, 0, -1, 0, 2'b00, -1, -1, 8};

    // Whole-line vectors
    for (int t = 0; t < 6; t++) begin
      int pre, pre2, npk, endh, c1000, rep, errs;
      logic [1:0] g0, pg;
      logic [3:0] pc;
      pre = -1; pre2 = -1; npk = 0; endh = -1;
      c1000 = 0; rep = 0; errs = 0;
      g0 = '0; pg = '0; pc = '0;
      do_reset();
      vid_line = tbl[t].vl;
      vid_next = tbl[t].vn;
      enable = tbl[t].en;
      for (int h = 0; h < HT; h++) begin
        req = (h >= tbl[t].req_on) ? tbl[t].rq : 2'b00;
        step(h);
        if (ctl == 4'b1010 && pc != 4'b1010) begin
          if (pre < 0) pre = h;
          else if (pre2 < 0) pre2 = h;
        end
        pc = ctl;
        if (pkt_start && pre2 < 0) begin
          npk++;
          if (npk == 1) g0 = gnt;
          else if (gnt == pg) rep++;
          pg = gnt;
        end
        if (gb && pre2 < 0) endh = h;
        if (ctl == 4'b1000) c1000++;
        if (err) errs++;
      end
      check($sformatf("tbl%0d_pre_start", t), pre, tbl[t].pre);
      check($sformatf("tbl%0d_packets", t), npk, tbl[t].npk);
      check($sformatf("tbl%0d_first_gnt", t), 32'(g0), 32'(tbl[t].g0));
      check($sformatf("tbl%0d_island_end", t), endh, tbl[t].endh);
      check($sformatf("tbl%0d_second_pre", t), pre2, tbl[t].pre2);
      check($sformatf("tbl%0d_ctl1000_cycles", t), c1000, tbl[t].c1000);
      check($sformatf("tbl%0d_err_pulses", t), errs, 0);
      if (tbl[t].rq == 2'b11)
        check($sformatf("tbl%0d_rr_repeats", t), rep, 0);
    end

    // Single-packet island, phase by phase
    begin
      int bad [6];
      int rel, ph;
      bit got;
      logic [15:0] ex;
      for (int i = 0; i < 6; i++) bad[i] = 0;
      got = 0;
      do_reset();
      vid_line = 1'b1;
      vid_next = 1'b1;
      enable = 1'b1;
      for (int h = 0; h <= 1340; h++) begin
        req = (h >= 1280 && !got) ? 2'b01 : 2'b00;
        step(h);
        if (pkt_start) got = 1;
        rel = h - 1292;
        if (rel < 0) begin ph = 0; ex = 16'h0000; end
        else if (rel < 8) begin ph = 1; ex = 16'h0050; end
        else if (rel < 10) begin ph = 2; ex = 16'h0002; end
        else if (rel < 42) begin
          ph = 3;
          ex = {2'b01, rel == 10, rel == 41, 5'(rel - 10),
                4'b0000, 3'b100};
        end
        else if (rel < 44) begin ph = 4; ex = 16'h0002; end
        else begin ph = 5; ex = 16'h0000; end
        if (outs() != ex) bad[ph]++;
      end
      check("seq1_pre_idle", bad[0], 0);
      check("seq1_preamble", bad[1], 0);
      check("seq1_lead_gb", bad[2], 0);
      check("seq1_data", bad[3], 0);
      check("seq1_trail_gb", bad[4], 0);
      check("seq1_post_idle", bad[5], 0);
    end

    // Asynchronous reset mid-packet, then round-robin restart
    begin
      bit hit;
      hit = 0;
      do_reset();
      vid_line = 1'b0;
      vid_next = 1'b0;
      enable = 1'b1;
      req = 2'b11;
      for (int k = 0; k < 200 && !hit; k++) begin
        step(k);
        if (ade && pkt_idx == 5'd15) hit = 1;
      end
      check("rst_reach_idx15", 32'(hit), 1);
      check("rst_gnt_before", 32'(gnt), 1);
      #2 rst_in = 1'b1;
      #1 check("rst_async_outs", 32'(outs()), 0);
      @(posedge pix_clk);
      #1 rst_in = 1'b0;
      hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
        step(k);
        if (pkt_start) hit = 1;
      end
      check("rst_restart_pkt", 32'(hit), 1);
      check("rst_first_contention", 32'(gnt), 1);
    end

    // Enable dropped during preamble
    begin
      bit hit;
      int h, starts, ades, gbs, pres;
      hit = 0; h = 0;
      starts = 0; ades = 0; gbs = 0; pres = 0;
      do_reset();
      vid_line = 1'b0;
      vid_next = 1'b0;
      enable = 1'b1;
      req = 2'b11;
      for (int k = 0; k < 100 && !hit; k++) begin
        step(h);
        h++;
        if (ctl == 4'b1010) hit = 1;
      end
      check("en_reach_pre", 32'(hit), 1);
      enable = 1'b0;
      for (int k = 0; k < 120; k++) begin
        step(h);
        h++;
        if (pkt_start) starts++;
        if (ade) ades++;
        if (gb) gbs++;
        if (ctl == 4'b1010) pres++;
      end
      check("en_packets", starts, 1);
      check("en_data_cycles", ades, 32);
      check("en_gb_cycles", gbs, 4);
      check("en_pre_rest", pres, 7);
      check("en_final_idle", 32'(outs()), 0);
    end

    // hcnt forced into active video mid-island
    begin
      bit hit;
      int h;
      hit = 0; h = 1270;
      do_reset();
      vid_line = 1'b1;
      vid_next = 1'b1;
      enable = 1'b1;
      req = 2'b01;
      for (int k = 0; k < 100 && !hit; k++) begin
        step(h);
        h++;
        if (ade && pkt_idx == 5'd5) hit = 1;
      end
      check("err_reach_data", 32'(hit), 1);
      step(100);
      check("err_pulse", 32'(outs()), 1);
      step(101);
      check("err_clear", 32'(outs()), 0);
    end

    // Randomized lines against the model
    begin
      bit vl_cur, vl_nx, en, inj;
      int inj_h, hh;
      do_reset();
      model_reset();
      vl_cur = 1'($urandom % 2);
      vl_nx = 1'($urandom % 2);
      for (int ln = 0; ln < 8; ln++) begin
        en = ($urandom % 5) != 0;
        inj = ($urandom % 4) == 0;
        inj_h = int'($urandom_range(1300, 1620));
        for (int h = 0; h < HT; h++) begin
          hh = (inj && h == inj_h) ? 100 : h;
          if ($urandom % 300 == 0) en = !en;
          if (!m_isl && $urandom % 4 == 0)
            req = 2'b00;
          else if (m_isl && m_off != 9 && $urandom % 16 == 0)
            req = 2'b00;
          else
            req = 2'($urandom_range(1, 3));
          vid_line = vl_cur;
          vid_next = vl_nx;
          enable = en;
          model_step(hh, vl_cur, vl_nx, en, req);
          step(hh);
          check("rand_outs", 32'(outs()), 32'(e_out));
        end
        vl_cur = vl_nx;
        vl_nx = 1'($urandom % 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
